mismatch_checker: RTL and testbench

Synthesizable response checker that sits directly downstream of the device-under-test and its golden model. Each valid sample, it compares the reference output against the DUT output with a per-bit don't-care mask. It accumulates sample and error counts, the timestamp of the first mismatch, and a sticky per-bit error map. A start/stop run controller brackets each measurement window and produces a final pass/fail verdict.

---
 rtl/mismatch_checker.sv | 114 +++++++++++
 tb/tb_mismatch_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mismatch_checker.sv
// Masked reference-vs-DUT response checker with run bracketing, saturating statistics and pass/fail verdict.
// Latency 1 from sample edge to statistics; no backpressure, one sample may be accepted every cycle.
module mismatch_checker #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] ref_q,
    input  logic [WIDTH-1:0] dut_q,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] errors,
    output logic             first_err_valid,
    output logic [TS_W-1:0]  first_err_time,
    output logic [WIDTH-1:0] err_bits
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_samples;
    logic [CNT_W-1:0] r_errors;
    logic             r_first_vld;
    logic [TS_W-1:0]  r_first_time;
    logic [WIDTH-1:0] r_err_bits;
    logic [TS_W-1:0]  r_timer;

    logic [WIDTH-1:0] w_diff;
    logic             w_enter_run;
    logic             w_count;
    logic             w_mis;

    assign w_diff      = (ref_q ^ dut_q) & ~mask;
    // Stop has priority in RUN, so start only restarts from IDLE or DONE.
    assign w_enter_run = (r_state != S_RUN) && start;
    assign w_count     = (r_state == S_RUN) && sample_valid;
    assign w_mis       = w_count && (w_diff != '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (stop)  w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_samples    <= '0;
            r_errors     <= '0;
            r_first_vld  <= 1'b0;
            r_first_time <= '0;
            r_err_bits   <= '0;
            r_timer      <= '0;
        end else if (w_enter_run) begin
            r_samples    <= '0;
            r_errors     <= '0;
            r_first_vld  <= 1'b0;
            r_first_time <= '0;
            r_err_bits   <= '0;
            r_timer      <= '0;
        end else if (r_state == S_RUN) begin
            if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_count && (r_samples != '1)) begin
                r_samples <= r_samples + 1'b1;
            end
            if (w_mis) begin
                if (r_errors != '1) begin
                    r_errors <= r_errors + 1'b1;
                end
                r_err_bits <= r_err_bits | w_diff;
                if (!r_first_vld) begin
                    r_first_vld  <= 1'b1;
                    r_first_time <= r_timer;
                end
            end
        end
    end

    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign pass            = (r_state == S_DONE) && (r_errors == '0);
    assign samples         = r_samples;
    assign errors          = r_errors;
    assign first_err_valid = r_first_vld;
    assign first_err_time  = r_first_time;
    assign err_bits        = r_err_bits;

endmodule

// File: tb/tb_mismatch_checker.sv
// Directed bench for mismatch_checker with WIDTH=2, CNT_W=4 so saturation is reachable.
module tb_mismatch_checker;

    logic        clk;
    logic        areset;
    logic        start;
    logic        stop;
    logic        sample_valid;
    logic [1:0]  ref_q;
    logic [1:0]  dut_q;
    logic [1:0]  mask;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  samples;
    logic [3:0]  errors;
    logic        first_err_valid;
    logic [31:0] first_err_time;
    logic [1:0]  err_bits;

    int n_cmp;
    int n_fail;

    mismatch_checker #(
        .WIDTH(2),
        .CNT_W(4),
        .TS_W (32)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .start          (start),
        .stop           (stop),
        .sample_valid   (sample_valid),
        .ref_q          (ref_q),
        .dut_q          (dut_q),
        .mask           (mask),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .samples        (samples),
        .errors         (errors),
        .first_err_valid(first_err_valid),
        .first_err_time (first_err_time),
        .err_bits       (err_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic cyc(input logic st, input logic sp, input logic v,
                       input logic [1:0] r, input logic [1:0] d, input logic [1:0] m);
        start = st; stop = sp; sample_valid = v; ref_q = r; dut_q = d; mask = m;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
        ref_q = 2'd0; dut_q = 2'd0; mask = 2'd0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", pass); end
        n_cmp++; if (samples !== 4'd0) begin n_fail++; $display("FAIL reset_samples: got %0d expected 0", samples); end
        n_cmp++; if (errors !== 4'd0) begin n_fail++; $display("FAIL reset_errors: got %0d expected 0", errors); end
        n_cmp++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fev: got %b expected 0", first_err_valid); end
        n_cmp++; if (first_err_time !== 32'd0) begin n_fail++; $display("FAIL reset_fet: got %0d expected 0", first_err_time); end
        n_cmp++; if (err_bits !== 2'b00) begin n_fail++; $display("FAIL reset_err_bits: got %b expected 00", err_bits); end
        areset = 1'b0;
        // Mismatching sample plus stop while IDLE: nothing may change.
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 2'd0);
        n_cmp++; if (samples !== 4'd0) begin n_fail++; $display("FAIL idle_samples: got %0d expected 0", samples); end
        n_cmp++; if (errors !== 4'd0) begin n_fail++; $display("FAIL idle_errors: got %0d expected 0", errors); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_state: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_clean_sweep();
        logic [1:0] v;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL sweep_run_state: got busy=%b done=%b expected 1/0", busy, done); end
        // Last sample coincides with stop and must still be counted.
        for (int i = 0; i < 8; i++) begin
            v = 2'(i);
            cyc(1'b0, (i == 7), 1'b1, v, v, 2'd0);
        end
        n_cmp++; if (samples !== 4'd8) begin n_fail++; $display("FAIL sweep_samples: got %0d expected 8", samples); end
        n_cmp++; if (errors !== 4'd0) begin n_fail++; $display("FAIL sweep_errors: got %0d expected 0", errors); end
        n_cmp++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_fev: got %b expected 0", first_err_valid); end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sweep_done: got done=%b busy=%b expected 1/0", done, busy); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL sweep_pass: got %b expected 1", pass); end
    endtask

    task automatic test_first_err();
        logic [1:0] r;
        logic [1:0] d;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            r = 2'(i);
            d = (i == 3) ? 2'b01 : r;
            cyc(1'b0, 1'b0, 1'b1, r, d, 2'd0);
            if (i == 2) begin
                n_cmp++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_fev_early: got %b expected 0", first_err_valid); end
            end
            if (i == 3) begin
                n_cmp++; if (first_err_valid !== 1'b1 || errors !== 4'd1) begin n_fail++; $display("FAIL ferr_latency: got fev=%b errors=%0d expected 1/1", first_err_valid, errors); end
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (samples !== 4'd8) begin n_fail++; $display("FAIL ferr_samples: got %0d expected 8", samples); end
        n_cmp++; if (errors !== 4'd1) begin n_fail++; $display("FAIL ferr_errors: got %0d expected 1", errors); end
        n_cmp++; if (err_bits !== 2'b10) begin n_fail++; $display("FAIL ferr_err_bits: got %b expected 10", err_bits); end
        n_cmp++; if (first_err_time !== 32'd4) begin n_fail++; $display("FAIL ferr_time: got %0d expected 4", first_err_time); end
        n_cmp++; if (done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL ferr_verdict: got done=%b pass=%b expected 1/0", done, pass); end
    endtask

    task automatic test_mask();
        logic [1:0] r;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            r = 2'(i);
            cyc(1'b0, 1'b0, 1'b1, r, r ^ 2'b10, 2'b10);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (samples !== 4'd4) begin n_fail++; $display("FAIL mask_samples: got %0d expected 4", samples); end
        n_cmp++; if (errors !== 4'd0) begin n_fail++; $display("FAIL mask_errors: got %0d expected 0", errors); end
        n_cmp++; if (err_bits !== 2'b00) begin n_fail++; $display("FAIL mask_err_bits: got %b expected 00", err_bits); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL mask_pass: got %b expected 1", pass); end
        // Same traffic unmasked; first sample lands in the first RUN cycle, timer 0.
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            r = 2'(i);
            cyc(1'b0, 1'b0, 1'b1, r, r ^ 2'b10, 2'b00);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (errors !== 4'd4) begin n_fail++; $display("FAIL nomask_errors: got %0d expected 4", errors); end
        n_cmp++; if (err_bits !== 2'b10) begin n_fail++; $display("FAIL nomask_err_bits: got %b expected 10", err_bits); end
        n_cmp++; if (first_err_valid !== 1'b1 || first_err_time !== 32'd0) begin n_fail++; $display("FAIL nomask_first: got fev=%b fet=%0d expected 1/0", first_err_valid, first_err_time); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL nomask_pass: got %b expected 0", pass); end
    endtask

    task automatic test_saturate();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00);
        end
        n_cmp++; if (samples !== 4'd15) begin n_fail++; $display("FAIL sat_samples: got %0d expected 15", samples); end
        n_cmp++; if (errors !== 4'd15) begin n_fail++; $display("FAIL sat_errors: got %0d expected 15", errors); end
        n_cmp++; if (err_bits !== 2'b11) begin n_fail++; $display("FAIL sat_err_bits: got %b expected 11", err_bits); end
        // start and stop together while running: stop wins, no restart.
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sat_startstop: got done=%b busy=%b expected 1/0", done, busy); end
        n_cmp++; if (samples !== 4'd15 || errors !== 4'd15) begin n_fail++; $display("FAIL sat_kept: got samples=%0d errors=%0d expected 15/15", samples, errors); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b expected 0", pass); end
    endtask

    task automatic test_areset_midrun();
        logic [1:0] r;
        logic [1:0] d;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            r = 2'(i);
            d = (i == 1 || i == 3) ? (r ^ 2'b01) : r;
            cyc(1'b0, 1'b0, 1'b1, r, d, 2'd0);
        end
        n_cmp++; if (samples !== 4'd5 || errors !== 4'd2) begin n_fail++; $display("FAIL arst_pre: got samples=%0d errors=%0d expected 5/2", samples, errors); end
        n_cmp++; if (first_err_time !== 32'd1) begin n_fail++; $display("FAIL arst_pre_fet: got %0d expected 1", first_err_time); end
        #2;
        areset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL arst_state: got busy=%b done=%b pass=%b expected 0/0/0", busy, done, pass); end
        n_cmp++; if (samples !== 4'd0 || errors !== 4'd0) begin n_fail++; $display("FAIL arst_counts: got samples=%0d errors=%0d expected 0/0", samples, errors); end
        n_cmp++; if (first_err_valid !== 1'b0 || first_err_time !== 32'd0 || err_bits !== 2'b00) begin n_fail++; $display("FAIL arst_first: got fev=%b fet=%0d bits=%b expected 0/0/00", first_err_valid, first_err_time, err_bits); end
        #2;
        areset = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            r = 2'(i + 1);
            cyc(1'b0, 1'b0, 1'b1, r, r, 2'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (samples !== 4'd3) begin n_fail++; $display("FAIL arst_rerun_samples: got %0d expected 3", samples); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL arst_rerun_pass: got %b expected 1", pass); end
    endtask

    task automatic test_restart();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (errors !== 4'd2 || pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL rst_failrun: got errors=%0d pass=%b done=%b expected 2/0/1", errors, pass, done); end
        // Samples offered in DONE are ignored.
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 2'd0);
        n_cmp++; if (samples !== 4'd2 || errors !== 4'd2) begin n_fail++; $display("FAIL rst_frozen: got samples=%0d errors=%0d expected 2/2", samples, errors); end
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 2'd0);
        n_cmp++; if (samples !== 4'd0 || errors !== 4'd0) begin n_fail++; $display("FAIL rst_coincident: got samples=%0d errors=%0d expected 0/0", samples, errors); end
        n_cmp++; if (first_err_valid !== 1'b0 || err_bits !== 2'b00) begin n_fail++; $display("FAIL rst_cleared: got fev=%b bits=%b expected 0/00", first_err_valid, err_bits); end
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL rst_state: got busy=%b done=%b pass=%b expected 1/0/0", busy, done, pass); end
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        n_cmp++; if (samples !== 4'd0) begin n_fail++; $display("FAIL rst_next: got %0d expected 0", samples); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_clean_sweep();
        test_first_err();
        test_mask();
        test_saturate();
        test_areset_midrun();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
